// File: rtl/gumnut_imem_pkg.sv
// Shared types and helpers for the Gumnut instruction memory.
// Parity option is enabled by defining GUMNUT_IMEM_PARITY_EN.
package gumnut_imem_pkg;

  localparam int IMEM_ADDR_W = 12;
  localparam int IMEM_DATA_W = 18;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } imem_state_e;

  // Even parity: returned bit makes the total count of ones even.
  function automatic logic even_par(
    input logic [63:0] d
  );
    return ^d;
  endfunction

endpackage

// File: rtl/gumnut_inst_mem_if.sv
// Instruction-fetch bus between the PC unit and the instruction memory.
// Classic cyc/stb request with a single-cycle ack.
interface gumnut_inst_mem_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 18
);

  logic              cyc_i;
  logic              stb_i;
  logic [ADDR_W-1:0] adr_i;
  logic              ack_o;
  logic [DATA_W-1:0] dat_o;

  modport master (
    output cyc_i,
    output stb_i,
    output adr_i,
    input  ack_o,
    input  dat_o
  );

  modport slave (
    input  cyc_i,
    input  stb_i,
    input  adr_i,
    output ack_o,
    output dat_o
  );

endinterface

// File: rtl/gumnut_imem_ram.sv
// Single-port synchronous array with registered read address.
// Write and address capture are both gated by en.
module gumnut_imem_ram #(
  parameter int DEPTH = 4096,
  parameter int WIDTH = 18,
  parameter int AW    = 12
) (
  input  logic             clk,
  input  logic             en,
  input  logic             we,
  input  logic [AW-1:0]    adr,
  input  logic [WIDTH-1:0] wdat,
  output logic [WIDTH-1:0] rdat
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    adr_q;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[adr] <= wdat;
      end
      adr_q <= adr;
    end
  end

  assign rdat = mem[adr_q];

endmodule

// File: rtl/gumnut_inst_mem.sv
// Gumnut instruction-memory responder: fetch FSM with wait states + loader.
// Define GUMNUT_IMEM_PARITY_EN to store and check a parity bit per word.
module gumnut_inst_mem
  import gumnut_imem_pkg::*;
#(
  parameter int ADDR_W      = IMEM_ADDR_W,
  parameter int DATA_W      = IMEM_DATA_W,
  parameter int DEPTH       = 4096,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cen,
  gumnut_inst_mem_if.slave  bus,
  input  logic              ld_we_i,
  input  logic [ADDR_W-1:0] ld_adr_i,
  input  logic [DATA_W-1:0] ld_dat_i,
  output logic              ld_busy_o,
  output logic              err_o
);

  localparam int RAW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [3:0] WS_L = 4'(WAIT_STATES);

`ifdef GUMNUT_IMEM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  imem_state_e       state_q;
  imem_state_e       state_d;
  logic [3:0]        cnt_q;
  logic [3:0]        cnt_d;
  logic [ADDR_W-1:0] adr_q;
  logic [ADDR_W-1:0] adr_d;

  logic              req;
  logic              idle;
  logic              ld_in;
  logic              in_rng;
  logic              fire;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_adr;
  logic [MEM_W-1:0]  wdat;
  logic [MEM_W-1:0]  rdat;

  assign req    = bus.cyc_i & bus.stb_i;
  assign idle   = (state_q == IDLE);
  assign ld_in  = ({1'b0, ld_adr_i} < DEPTH_L);
  assign in_rng = ({1'b0, adr_q} < DEPTH_L);

  always_ff @(posedge clk) begin
    if (cen) begin
      if (!rst) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        adr_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        adr_q   <= adr_d;
      end
    end
  end

  // Loader has priority over a fetch request arriving in the same idle cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    unique case (state_q)
      IDLE: begin
        if (!ld_we_i && req) begin
          adr_d   = bus.adr_i;
          cnt_d   = WS_L;
          state_d = (WAIT_STATES > 0) ? WAIT : ACK;
        end
      end
      WAIT: begin
        if (!req) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == 4'd1) begin
          state_d = ACK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // In IDLE the array address follows the loader or the incoming fetch,
  // so the registered read address is already correct on entry to ACK.
  always_comb begin
    ram_adr = adr_q;
    if (idle) begin
      ram_adr = ld_we_i ? ld_adr_i : bus.adr_i;
    end
  end

  assign ram_we = idle & ld_we_i & ld_in;

  gumnut_imem_ram #(
    .DEPTH (DEPTH),
    .WIDTH (MEM_W),
    .AW    (RAW)
  ) u_ram (
    .clk  (clk),
    .en   (cen),
    .we   (ram_we),
    .adr  (ram_adr[RAW-1:0]),
    .wdat (wdat),
    .rdat (rdat)
  );

  assign fire      = (state_q == ACK) & in_rng;
  assign bus.ack_o = (state_q == ACK);
  assign bus.dat_o = fire ? rdat[DATA_W-1:0] : '0;
  assign ld_busy_o = ~idle;

`ifdef GUMNUT_IMEM_PARITY_EN
  assign wdat  = {even_par(64'(ld_dat_i)), ld_dat_i};
  assign err_o = fire &
                 (even_par(64'(rdat[DATA_W-1:0])) != rdat[DATA_W]);
`else
  assign wdat  = ld_dat_i;
  assign err_o = 1'b0;
`endif

endmodule
